// File: rtl/mdq_pkg.sv
// Shared types and constants for the multiply/divide writeback queue.
//
// entry state | meaning
// ENT_FREE    | slot unused, available for allocation
// ENT_PENDING | op issued, result not yet returned by the functional unit
// ENT_DONE    | result latched, waiting for its in-order turn to commit
package mdq_pkg;

  typedef enum logic [1:0] {
    ENT_FREE    = 2'd0,
    ENT_PENDING = 2'd1,
    ENT_DONE    = 2'd2
  } entry_state_t;

  // Exception commits go to rstatus with a cause code.
  localparam int STATUS_REG = 30;
  localparam int EXC_MULT   = 4;
  localparam int EXC_DIV    = 5;

endpackage

// File: rtl/mdq_hazard_cmp.sv
// Per-entry hazard comparator: flags an outstanding destination that matches
// any of the three DX check addresses. Register 0 never matches.
module mdq_hazard_cmp #(
  parameter int REG_AW = 5
) (
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_chk_a,
  input  logic [REG_AW-1:0] i_chk_b,
  input  logic [REG_AW-1:0] i_chk_d,
  output logic              o_match
);

  logic w_rd_nz;

  // A nonzero rd that equals a check address implies the check address is nonzero too.
  assign w_rd_nz = |i_rd;
  assign o_match = i_valid && w_rd_nz &&
                   ((i_rd == i_chk_a) || (i_rd == i_chk_b) || (i_rd == i_chk_d));

endmodule

// File: rtl/multdiv_writeback_queue.sv
// Completion/writeback buffer for long-latency multiply/divide ops.
// Allocates tags in issue order, accepts out-of-order completions and commits
// in issue order whenever the MW stage is not using the regfile write port.
// Optional feature: MULTDIV_WBQ_EXC_EN redirects excepting results to rstatus.
module multdiv_writeback_queue
  import mdq_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_AW = 5,
  parameter  int DEPTH  = 4,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_is_div,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              done_valid,
  input  logic [TAG_W-1:0]  done_tag,
  input  logic [DATA_W-1:0] done_data,
  input  logic              done_exc,
  input  logic              mw_we,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] chk_a,
  input  logic [REG_AW-1:0] chk_b,
  input  logic [REG_AW-1:0] chk_d,
  output logic              hazard,
  output logic [TAG_W:0]    count,
  output logic              tag_err
);

  entry_state_t      r_state [DEPTH];
  logic [REG_AW-1:0] r_rd    [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
`ifdef MULTDIV_WBQ_EXC_EN
  logic              r_exc    [DEPTH];
  logic              r_is_div [DEPTH];
`endif
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;
  logic              r_tag_err;

  logic              w_issue;
  logic              w_head_done;
  logic              w_retire;
  logic              w_done_hit;
  logic [DEPTH-1:0]  w_match;
  logic              w_status_hz;

`ifndef MULTDIV_WBQ_EXC_EN
  // Exception and op-type inputs have no effect when the feature is disabled.
  logic w_unused;
  assign w_unused = ^{issue_is_div, done_exc};
`endif

  // No look-ahead: a same-cycle retire does not make room for an issue.
  assign issue_ready = (r_count < (TAG_W+1)'(DEPTH));
  assign issue_tag   = r_tail;
  assign count       = r_count;
  assign tag_err     = r_tag_err;

  assign w_issue     = issue_valid && issue_ready;
  assign w_head_done = (r_state[r_head] == ENT_DONE);
  assign w_retire    = w_head_done && !mw_we;
  assign w_done_hit  = (r_state[done_tag] == ENT_PENDING);

  // Entry state, pointers, occupancy and sticky tag error.
  // Retire, completion and issue never target the same slot in one cycle:
  // the retiring head is DONE (not PENDING), and the issue slot is FREE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= ENT_FREE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_retire) begin
        r_state[r_head] <= ENT_FREE;
        r_head          <= r_head + TAG_W'(1);
      end
      if (done_valid) begin
        if (w_done_hit) r_state[done_tag] <= ENT_DONE;
        else            r_tag_err         <= 1'b1;
      end
      if (w_issue) begin
        r_state[r_tail] <= ENT_PENDING;
        r_tail          <= r_tail + TAG_W'(1);
      end
      if (w_issue && !w_retire)      r_count <= r_count + (TAG_W+1)'(1);
      else if (w_retire && !w_issue) r_count <= r_count - (TAG_W+1)'(1);
    end
  end

  // Payload storage; only meaningful while the matching state is not FREE.
  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_rd[r_tail] <= issue_rd;
`ifdef MULTDIV_WBQ_EXC_EN
      r_is_div[r_tail] <= issue_is_div;
`endif
    end
    if (done_valid && w_done_hit) begin
      r_data[done_tag] <= done_data;
`ifdef MULTDIV_WBQ_EXC_EN
      r_exc[done_tag] <= done_exc;
`endif
    end
  end

  // Commit request from the head entry; outputs are zero when not committing.
  always_comb begin
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    if (w_retire) begin
`ifdef MULTDIV_WBQ_EXC_EN
      if (r_exc[r_head]) begin
        wb_valid = 1'b1;
        wb_reg   = REG_AW'(STATUS_REG);
        wb_data  = r_is_div[r_head] ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MULT);
      end else if (|r_rd[r_head]) begin
        wb_valid = 1'b1;
        wb_reg   = r_rd[r_head];
        wb_data  = r_data[r_head];
      end
`else
      if (|r_rd[r_head]) begin
        wb_valid = 1'b1;
        wb_reg   = r_rd[r_head];
        wb_data  = r_data[r_head];
      end
`endif
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    mdq_hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
      .i_valid (r_state[g] != ENT_FREE),
      .i_rd    (r_rd[g]),
      .i_chk_a (chk_a),
      .i_chk_b (chk_b),
      .i_chk_d (chk_d),
      .o_match (w_match[g])
    );
  end

  // Any outstanding op may end up writing rstatus, so it is a hazard too.
`ifdef MULTDIV_WBQ_EXC_EN
  assign w_status_hz = (r_count != '0) &&
                       ((chk_a == REG_AW'(STATUS_REG)) || (chk_b == REG_AW'(STATUS_REG)) ||
                        (chk_d == REG_AW'(STATUS_REG)));
`else
  assign w_status_hz = 1'b0;
`endif

  // Reduce per-entry matches into the single DX stall source.
  always_comb begin
    hazard = w_status_hz;
    for (int i = 0; i < DEPTH; i++) hazard = hazard | w_match[i];
  end

endmodule

// File: tb/tb_multdiv_writeback_queue.sv
// Self-checking bench for multdiv_writeback_queue: directed scenarios plus a
// randomized run, all checked against an issue-order queue model.
module tb_multdiv_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_div;
  logic        issue_ready;
  logic [1:0]  issue_tag;
  logic        done_valid;
  logic [1:0]  done_tag;
  logic [31:0] done_data;
  logic        done_exc;
  logic        mw_we;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  chk_a, chk_b, chk_d;
  logic        hazard;
  logic [2:0]  count;
  logic        tag_err;

  always #5 clock = ~clock;

  multdiv_writeback_queue dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_div(issue_is_div),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data), .done_exc(done_exc),
    .mw_we(mw_we),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .chk_a(chk_a), .chk_b(chk_b), .chk_d(chk_d),
    .hazard(hazard), .count(count), .tag_err(tag_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: ops numbered in issue order; op k lives in tag k % DEPTH.
  int          n_iss, n_ret;
  logic [4:0]  m_rd   [DEPTH];
  logic [31:0] m_data [DEPTH];
  bit          m_done [DEPTH];
  bit          m_div  [DEPTH];
  bit          m_exc  [DEPTH];
  bit          m_err;

  task automatic model_reset();
    n_iss = 0;
    n_ret = 0;
    m_err = 0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
  endtask

  function automatic bit is_pending(int t);
    for (int k = 0; k < n_iss - n_ret; k++)
      if ((n_ret + k) % DEPTH == t) return !m_done[t];
    return 0;
  endfunction

  task automatic model_check();
    int outs, h, t;
    logic ev, eh;
    logic [4:0] er;
    logic [31:0] ed;
    outs = n_iss - n_ret;
    h = n_ret % DEPTH;
    ev = 0; er = 0; ed = 0; eh = 0;
    if (outs > 0 && m_done[h] && !mw_we) begin
`ifdef MULTDIV_WBQ_EXC_EN
      if (m_exc[h]) begin
        ev = 1; er = 5'd30; ed = m_div[h] ? 32'd5 : 32'd4;
      end else if (m_rd[h] != 0) begin
        ev = 1; er = m_rd[h]; ed = m_data[h];
      end
`else
      if (m_rd[h] != 0) begin
        ev = 1; er = m_rd[h]; ed = m_data[h];
      end
`endif
    end
    for (int k = 0; k < outs; k++) begin
      t = (n_ret + k) % DEPTH;
      if (m_rd[t] != 0 && (m_rd[t] == chk_a || m_rd[t] == chk_b || m_rd[t] == chk_d)) eh = 1;
    end
`ifdef MULTDIV_WBQ_EXC_EN
    if (outs > 0 && (chk_a == 30 || chk_b == 30 || chk_d == 30)) eh = 1;
`endif
    check_val("issue_ready", issue_ready, outs < DEPTH);
    check_val("issue_tag", issue_tag, n_iss % DEPTH);
    check_val("count", count, outs);
    check_val("wb_valid", wb_valid, ev);
    check_val("wb_reg", wb_reg, er);
    check_val("wb_data", wb_data, ed);
    check_val("hazard", hazard, eh);
    check_val("tag_err", tag_err, m_err);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_is_div = 0;
    done_valid = 0; done_tag = 0; done_data = 0; done_exc = 0;
    mw_we = 0; chk_a = 0; chk_b = 0; chk_d = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    model_check();
  endtask

  task automatic tick();
    int outs, h, t;
    bit ret, dpend, iss;
    outs  = n_iss - n_ret;
    h     = n_ret % DEPTH;
    ret   = outs > 0 && m_done[h] && !mw_we;
    dpend = done_valid && is_pending(int'(done_tag));
    iss   = issue_valid && outs < DEPTH;
    @(posedge clock);
    if (done_valid) begin
      if (dpend) begin
        m_done[done_tag] = 1;
        m_data[done_tag] = done_data;
        m_exc[done_tag]  = done_exc;
      end else m_err = 1;
    end
    if (iss) begin
      t = n_iss % DEPTH;
      m_rd[t] = issue_rd; m_div[t] = issue_is_div; m_done[t] = 0;
      n_iss++;
    end
    if (ret) n_ret++;
    @(negedge clock);
  endtask

  task automatic cyc();
    step();
    tick();
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    model_reset();
    #1;
    model_check();
    @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int outs;
    idle();
    model_reset();
    @(negedge clock);
    #1;
    model_check();
    check_val("rst_ready", issue_ready, 1);
    @(negedge clock);
    reset = 1;

    // Single op
    do_reset();
    issue_valid = 1; issue_rd = 7; step(); check_val("single_tag", issue_tag, 0); tick();
    idle(); cyc();
    done_valid = 1; done_tag = 0; done_data = 32'h2A; cyc();
    idle(); step();
    check_val("single_wbv", wb_valid, 1);
    check_val("single_reg", wb_reg, 7);
    check_val("single_data", wb_data, 32'h2A);
    tick();
    step(); check_val("single_cnt", count, 0); tick();

    // Out-of-order completion, in-order commit
    do_reset();
    issue_valid = 1; issue_rd = 3; cyc();
    issue_rd = 4; cyc();
    idle(); done_valid = 1; done_tag = 1; done_data = 32'h44; cyc();
    done_tag = 0; done_data = 32'h33; step(); check_val("ooo_hold", wb_valid, 0); tick();
    idle(); step(); check_val("ooo_first", wb_reg, 3); tick();
    step(); check_val("ooo_second", wb_reg, 4); tick();
    step(); check_val("ooo_empty", wb_valid, 0); tick();

    // Full and wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_rd = 5'(10 + i); cyc();
    end
    issue_rd = 14; step();
    check_val("full_ready", issue_ready, 0);
    check_val("full_cnt", count, 4);
    tick();
    idle(); step(); check_val("full_ignored", count, 4); tick();
    done_valid = 1; done_tag = 0; done_data = 32'h100; cyc();
    idle(); step(); check_val("full_ret", wb_reg, 10); tick();
    issue_valid = 1; issue_rd = 15; step();
    check_val("wrap_tag", issue_tag, 0);
    check_val("wrap_ready", issue_ready, 1);
    tick();
    idle(); step(); check_val("wrap_cnt", count, 4); tick();

    // Hazard and priority
    do_reset();
    issue_valid = 1; issue_rd = 9; cyc();
    idle(); chk_a = 9; step(); check_val("hz_r9", hazard, 1); tick();
    idle(); issue_valid = 1; issue_rd = 0; cyc();
    idle(); step(); check_val("hz_r0", hazard, 0); tick();
    done_valid = 1; done_tag = 0; done_data = 32'h99; mw_we = 1; cyc();
    idle(); mw_we = 1;
    for (int i = 0; i < 3; i++) begin
      step(); check_val("prio_hold", wb_valid, 0); tick();
    end
    mw_we = 0; step(); check_val("prio_release", wb_reg, 9); tick();
    done_valid = 1; done_tag = 1; done_data = 32'h5; cyc();
    idle(); step(); check_val("r0_nowb", wb_valid, 0); check_val("r0_cnt", count, 1); tick();
    step(); check_val("r0_retired", count, 0); tick();

    // Exception path
    do_reset();
    issue_valid = 1; issue_rd = 5; issue_is_div = 1; cyc();
    idle(); done_valid = 1; done_tag = 0; done_data = 32'h1234; done_exc = 1; cyc();
    idle(); step();
`ifdef MULTDIV_WBQ_EXC_EN
    check_val("exc_reg", wb_reg, 30);
    check_val("exc_data", wb_data, 5);
`else
    check_val("exc_reg", wb_reg, 5);
    check_val("exc_data", wb_data, 32'h1234);
`endif
    tick();

    // Tag error and async reset mid-operation
    do_reset();
    done_valid = 1; done_tag = 2; done_data = 32'h7; cyc();
    idle(); step(); check_val("err_set", tag_err, 1); tick();
    cyc(); check_val("err_sticky", tag_err, 1);
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_rd = 5'(1 + i); cyc();
    end
    idle(); chk_a = 1; step(); check_val("pre_rst_hz", hazard, 1);
    #1 reset = 0;
    #1;
    check_val("arst_cnt", count, 0);
    check_val("arst_hz", hazard, 0);
    check_val("arst_err", tag_err, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1;
    idle(); done_valid = 1; done_tag = 0; done_data = 32'h55; cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      step(); check_val("post_rst_nowb", wb_valid, 0); tick();
    end
    check_val("post_rst_err", tag_err, 1);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      idle();
      outs = n_iss - n_ret;
      issue_valid  = ($urandom_range(0, 99) < 45);
      issue_rd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue_is_div = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 50) begin
        done_valid = 1;
        if (outs > 0 && $urandom_range(0, 99) < 90)
          done_tag = 2'((n_ret + int'($urandom_range(0, outs - 1))) % DEPTH);
        else
          done_tag = 2'($urandom_range(0, 3));
        done_data = $urandom;
        done_exc  = ($urandom_range(0, 9) == 0);
      end
      mw_we = ($urandom_range(0, 99) < 30);
      if (outs > 0 && $urandom_range(0, 1) == 1)
        chk_a = m_rd[(n_ret + int'($urandom_range(0, outs - 1))) % DEPTH];
      else chk_a = 5'($urandom_range(0, 31));
      chk_b = 5'($urandom_range(0, 31));
      if (outs > 0 && $urandom_range(0, 3) == 0)
        chk_d = m_rd[(n_ret + int'($urandom_range(0, outs - 1))) % DEPTH];
      else chk_d = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/multdiv_writeback_queue.md
# multdiv_writeback_queue

Parametrised completion and writeback buffer for long-latency multiply/divide operations.
- Sits between the multdiv unit(s) and the regfile write port, alongside the MW stage.
- Allocates an in-order tag per issued op and accepts out-of-order completions. Commits results to the regfile in issue order whenever the main pipeline is not writing.
- Reports RAW/WAW hazards against all outstanding destinations. DX uses this as its stall source.

## Interface
Parameters:
- DATA_W, 32, result/writeback data width
- REG_AW, 5, register address width
- DEPTH, 4, max outstanding ops; power of two, ≥2; TAG_W = $clog2(DEPTH)

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- issue_valid  in  1  DX issues a mult/div this cycle
- issue_rd  in  REG_AW  destination register of issued op
- issue_is_div  in  1  1 = div, 0 = mult
- issue_ready  out  1  a free entry exists
- issue_tag  out  TAG_W  tag assigned to the op issued this cycle (= tail pointer)
- done_valid  in  1  functional unit reports completion
- done_tag  in  TAG_W  tag of completed op
- done_data  in  DATA_W  result
- done_exc  in  1  op raised an exception (overflow / divide by zero)
- mw_we  in  1  MW stage writes the regfile this cycle (has priority)
- wb_valid  out  1  commit write request to the regfile
- wb_reg  out  REG_AW  commit destination
- wb_data  out  DATA_W  commit data
- chk_a, chk_b, chk_d  in  REG_AW  DX source A, source B, destination
- hazard  out  1  any outstanding entry's rd equals a nonzero chk_a, chk_b or chk_d
- count  out  TAG_W+1  occupied entries
- tag_err  out  1  sticky: done_valid arrived for an entry that was not PENDING

## Operation
- Circular buffer of DEPTH entries. Entry fields:
  - state: FREE / PENDING / DONE
  - rd, is_div, exc
  - data
- Pointers: head (oldest), tail (next allocation); counter count.
- Issue: on a clock edge with issue_valid && issue_ready:
  - entry[tail] ← PENDING with rd and is_div;
  - tail+1 mod DEPTH; count+1.
  - issue_valid while !issue_ready is ignored; the controller must already be stalling.
- Completion: on a clock edge with done_valid:
  - if entry[done_tag] is PENDING → state DONE, latch data and exc;
  - otherwise no state change and tag_err ← 1.
- Commit: wb_valid = head entry DONE && !mw_we && head rd ≠ 0.
  - Head retires (→ FREE, head+1, count−1) on an edge where head is DONE and !mw_we.
  - An rd = 0 entry retires without asserting wb_valid.
- Hazard: combinational OR over every PENDING or DONE entry. Register 0 never matches. The entry being issued in the same cycle is not yet visible.
- issue_ready = (count < DEPTH). There is no look-ahead for a same-cycle retire.
- Simultaneous issue + retire: count is unchanged and both pointers advance.
- Simultaneous done_valid and retire on different tags: both take effect.

## Timing
- Reset values:
  - all entries FREE; head = tail = 0; count = 0; tag_err = 0;
  - wb_valid = 0; wb_reg = 0; wb_data = 0; hazard = 0; issue_ready = 1; issue_tag = 0.
- Minimum done → wb_valid latency: 1 cycle, since completion is registered and there is no same-cycle bypass.
- wb_valid, wb_reg, wb_data and hazard are combinational from registered state plus mw_we and the chk_* inputs.
- Back-to-back commits: one per cycle while the head is DONE and mw_we = 0.
- While mw_we = 1, commits are held indefinitely with no starvation counter.
- Wrap-around: pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Reset asserted mid-operation discards all outstanding ops. Completions arriving after reset deassertion hit FREE entries and set tag_err.

## Configuration
- MULTDIV_WBQ_EXC_EN defined: a DONE entry with exc = 1 commits to register 30 (rstatus) instead of rd. Data is 4 for mult or 5 for div. The rd = 0 suppression does not apply. The hazard check additionally treats register 30 as a destination of every outstanding entry.
- MULTDIV_WBQ_EXC_EN undefined: done_exc is ignored and the result always commits to rd. The exc field is not stored.

## Structure
- Package mdq_pkg holds:
  - entry state enum (FREE, PENDING, DONE);
  - constants STATUS_REG = 30, EXC_MULT = 4, EXC_DIV = 5.
- Sub-module mdq_hazard_cmp: per-entry comparator (valid, rd vs three check addresses, r0 masking). It is instantiated DEPTH times and its outputs are ORed in the parent.

## Test plan
- Single op: issue rd = 7 (tag 0), done_valid tag 0 data 0x2A two cycles later, mw_we = 0 → wb_valid next cycle with wb_reg = 7, wb_data = 0x2A; count returns to 0.
- Out-of-order completion: issue rd = 3 (tag 0), then rd = 4 (tag 1); complete tag 1 first, then tag 0 → commits are r3 then r4 on consecutive cycles, never r4 first.
- Full and wrap, DEPTH = 4:
  - issue 4 ops → issue_ready = 0, count = 4; a 5th issue_valid is ignored;
  - retire one → next issue receives tag 0 after wrap.
- Hazard and priority:
  - with r9 outstanding, chk_a = 9 → hazard = 1; chk_a = 0 with an rd = 0 entry → hazard = 0;
  - holding mw_we = 1 keeps wb_valid = 0 and the entry DONE until mw_we drops.
- Exception with MULTDIV_WBQ_EXC_EN: div to rd = 5 completes with done_exc = 1 → wb_reg = 30, wb_data = 5. Without the macro → wb_reg = 5, wb_data = done_data.
- Errors and reset: done_valid on a FREE tag → tag_err = 1 and stays set. Reset asserted with 3 entries outstanding → count = 0 and hazard = 0 immediately, with no commits afterwards.
